dropout_lanes_lfsr: RTL and testbench
=====================================

// Module: dropout_lanes_lfsr
// PURPOSE
//  Parametrised streaming random-dropout unit: LANES x DATA_W words per beat; each lane independently
//  zeroed with programmable probability from an on-chip Galois LFSR. Optional inverted-dropout
//  scaling of kept lanes; valid/ready streaming with one output register; saturating drop statistic.
//  Sits between ui_in capture logic and the output pins in the tt_um_* top level.
// PARAMETERS
//  LANES    4             number of lanes per beat
//  DATA_W   8             bits per lane (unsigned)
//  RATE_W   8             random/threshold width per lane; LANES*RATE_W <= LFSR_W required
//  LFSR_W   32            LFSR width
//  POLY     32'h80200003  Galois feedback mask (x^32+x^22+x^2+x+1)
//  SEED     32'hACE1_2025 reset seed, and substitute for an all-zero seed_val
// PORTS
//  clk         in   1              single clock, rising edge
//  rst_n       in   1              synchronous reset, active low
//  ena         in   1              block enable; low = freeze (no accept, no LFSR step)
//  cfg_rate    in   RATE_W         drop threshold: lane dropped when its random field < cfg_rate
//  cfg_scale   in   1              1 = kept lanes shifted left by cfg_shift, saturating
//  cfg_shift   in   2              scale shift amount 0..3
//  seed_load   in   1              load LFSR from seed_val this cycle
//  seed_val    in   LFSR_W         seed value
//  stat_clr    in   1              clear drop_count
//  in_valid    in   1              input beat valid
//  in_ready    out  1              input beat accepted when in_valid & in_ready
//  in_data     in   LANES*DATA_W   lane i = in_data[i*DATA_W +: DATA_W]
//  out_valid   out  1              output beat valid
//  out_ready   in   1              downstream accept
//  out_data    out  LANES*DATA_W   processed lanes
//  out_mask    out  LANES          bit i = 1 if lane i kept
//  drop_count  out  16             saturating count of dropped lanes
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): lfsr=SEED, out_valid=0, out_data=0, out_mask=0, drop_count=0.
//   Reset mid-beat discards the held output beat; in_ready=0 while rst_n=0.
//  in_ready = ena & rst_n & (~out_valid | out_ready) (combinational). Accept = in_valid & in_ready.
//  Latency 1: beat accepted at edge k appears on out_* after edge k; held stable until out_valid &
//   out_ready. Full throughput: one beat/cycle when out_ready stays high.
//  ena=0: no accept, LFSR frozen, out_valid/out_data held; output may still drain if out_ready=1.
//  Per accepted beat: r_i = lfsr[i*RATE_W +: RATE_W] (current, pre-step value). drop_i = (r_i < cfg_rate).
//   cfg_rate=0 never drops; cfg_rate=2^RATE_W-1 drops unless r_i is all-ones. cfg_* sampled at accept.
//  Kept lane: cfg_scale=0 -> passthrough; cfg_scale=1 -> lane<<cfg_shift, saturated to 2^DATA_W-1 if any
//   bit shifted out is 1. Dropped lane: 0. out_mask_i = ~drop_i.
//  LFSR steps exactly once per accepted beat: lfsr = (lfsr>>1) ^ (lfsr[0] ? POLY : 0). Never steps otherwise.
//  seed_load (needs ena=1): lfsr = (seed_val==0) ? SEED : seed_val; takes priority over stepping; a beat
//   accepted in the same cycle uses the pre-load value. Lock-up (all-zero state) is thus unreachable.
//  drop_count += popcount(drop) on each accept, saturating at 16'hFFFF (no wrap). stat_clr wins over
//   increment in the same cycle (that beat's drops not counted).
// TESTING
//  T1 rate=0, scale=0, 20 beats of random data -> out_data==in_data, out_mask=4'hF, drop_count=0.
//  T2 rate=0, scale=1, shift=1, lanes {0x90,0x50,0x7F,0x80} -> out {0xFF,0xA0,0xFE,0xFF}; shift=3, 0x1F -> 0xF8.
//  T3 seed_load seed_val=0 then 1000 beats rate=0x80 -> LFSR/mask/drops match golden model started from SEED;
//     drop fraction 0.45..0.55; seed_val=0x1 reload reproduces model sequence from 0x1.
//  T4 out_ready low 5 cycles mid-stream, in_valid high -> in_ready=0, out_data/out_mask stable,
//     LFSR frozen; resumed stream matches unstalled model beat-for-beat; same for ena low 5 cycles.
//  T5 rate=0xFF, seed 0x1 beats until count saturates -> drop_count stops at 16'hFFFF; stat_clr with
//     simultaneous accept -> drop_count=0 next cycle.
//  T6 rst_n low 1 cycle with out_valid=1 held -> next cycle out_valid=0, out_data=0, drop_count=0, lfsr=SEED.

Source files
------------

// File: rtl/dropout_lanes_lfsr.sv
// Streaming random-dropout unit: each lane of a beat is zeroed when its slice of a Galois LFSR
// falls below cfg_rate; kept lanes optionally scaled by a saturating left shift.
module dropout_lanes_lfsr #(
  parameter int                LANES  = 4,
  parameter int                DATA_W = 8,
  parameter int                RATE_W = 8,
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] POLY   = 32'h8020_0003,
  parameter logic [LFSR_W-1:0] SEED   = 32'hACE1_2025
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [RATE_W-1:0]         cfg_rate,
  input  logic                      cfg_scale,
  input  logic [1:0]                cfg_shift,
  input  logic                      seed_load,
  input  logic [LFSR_W-1:0]         seed_val,
  input  logic                      stat_clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_mask,
  output logic [15:0]               drop_count
);

  function automatic logic [LFSR_W-1:0] f_lfsr_step(input logic [LFSR_W-1:0] s);
    f_lfsr_step = (s >> 1) ^ (s[0] ? POLY : {LFSR_W{1'b0}});
  endfunction

  function automatic logic [DATA_W-1:0] f_scale(input logic [DATA_W-1:0] d,
                                                input logic [1:0]        sh);
    logic [DATA_W+2:0] w;
    w = {3'b000, d} << sh;
    if (w[DATA_W+2 -: 3] != 3'b000) begin
      f_scale = {DATA_W{1'b1}};
    end else begin
      f_scale = w[DATA_W-1:0];
    end
  endfunction

  function automatic logic [15:0] f_popcount(input logic [LANES-1:0] m);
    f_popcount = 16'd0;
    for (int i = 0; i < LANES; i++) begin
      f_popcount = f_popcount + {15'd0, m[i]};
    end
  endfunction

  logic [LFSR_W-1:0]       r_lfsr;
  logic                    r_out_valid;
  logic [LANES*DATA_W-1:0] r_out_data;
  logic [LANES-1:0]        r_out_mask;
  logic [15:0]             r_drop_count;

  logic                    w_accept;
  logic [LANES-1:0]        w_drop;
  logic [LANES*DATA_W-1:0] w_proc;
  logic [LFSR_W-1:0]       w_lfsr_nxt;
  logic [16:0]             w_cnt_sum;
  logic [15:0]             w_cnt_nxt;

  assign in_ready = ena & rst_n & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  // Lane randomness comes from the pre-step LFSR value of the accepting cycle.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_drop[g] = (r_lfsr[g*RATE_W +: RATE_W] < cfg_rate);
    assign w_proc[g*DATA_W +: DATA_W] =
      w_drop[g] ? {DATA_W{1'b0}} :
      (cfg_scale ? f_scale(in_data[g*DATA_W +: DATA_W], cfg_shift)
                 : in_data[g*DATA_W +: DATA_W]);
  end

  // LFSR next state: a seed load overrides the per-beat step.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (ena && seed_load) begin
      w_lfsr_nxt = (seed_val == {LFSR_W{1'b0}}) ? SEED : seed_val;
    end else if (w_accept) begin
      w_lfsr_nxt = f_lfsr_step(r_lfsr);
    end else begin
      w_lfsr_nxt = r_lfsr;
    end
  end

  // Drop statistic next state, saturating; clear beats a concurrent increment.
  always_comb begin
    w_cnt_sum = {1'b0, r_drop_count} + {1'b0, f_popcount(w_drop)};
    w_cnt_nxt = r_drop_count;
    if (stat_clr) begin
      w_cnt_nxt = 16'd0;
    end else if (w_accept) begin
      w_cnt_nxt = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end else begin
      w_cnt_nxt = r_drop_count;
    end
  end

  // State and output register; output data is held until the next accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr       <= SEED;
      r_out_valid  <= 1'b0;
      r_out_data   <= {(LANES*DATA_W){1'b0}};
      r_out_mask   <= {LANES{1'b0}};
      r_drop_count <= 16'd0;
    end else begin
      r_lfsr       <= w_lfsr_nxt;
      r_drop_count <= w_cnt_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_proc;
        r_out_mask  <= ~w_drop;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_mask   = r_out_mask;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_dropout_lanes_lfsr.sv
// Self-checking bench for dropout_lanes_lfsr: per-cycle behavioural model plus table and
// hand-written corner sequences.
module tb_dropout_lanes_lfsr;

  localparam logic [31:0] SEED = 32'hACE1_2025;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst_n, ena, cfg_scale, seed_load, stat_clr, in_valid, out_ready;
  logic [7:0]  cfg_rate;
  logic [1:0]  cfg_shift;
  logic [31:0] seed_val, in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_mask;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  dropout_lanes_lfsr dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_rate(cfg_rate), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .seed_load(seed_load), .seed_val(seed_val), .stat_clr(stat_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask), .drop_count(drop_count)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_lfsr = SEED;
  logic        m_ov   = 1'b0;
  logic [31:0] m_od   = 32'd0;
  logic [3:0]  m_om   = 4'd0;
  int unsigned m_cnt  = 0;
  logic        last_acc;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  shift;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check in_ready, advance the model, then compare registered outputs.
  task automatic tick();
    logic        exp_rdy;
    logic [31:0] nd;
    logic [3:0]  nm;
    logic [7:0]  r;
    int unsigned v;
    int          drops;
    #1;
    exp_rdy = ena && rst_n && (!m_ov || out_ready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    last_acc = in_valid && exp_rdy;
    if (!rst_n) begin
      m_lfsr = SEED; m_ov = 1'b0; m_od = 32'd0; m_om = 4'd0; m_cnt = 0;
    end else begin
      drops = 0; nd = 32'd0; nm = 4'd0;
      for (int i = 0; i < 4; i++) begin
        r = m_lfsr[i*8 +: 8];
        if (r < cfg_rate) begin
          drops++;
        end else begin
          nm[i] = 1'b1;
          v = in_data[i*8 +: 8];
          if (cfg_scale) v = v << cfg_shift;
          if (v > 255) v = 255;
          nd[i*8 +: 8] = v[7:0];
        end
      end
      if (stat_clr) m_cnt = 0;
      else if (last_acc) begin
        m_cnt = m_cnt + drops;
        if (m_cnt > 65535) m_cnt = 65535;
      end
      if (ena && seed_load) m_lfsr = (seed_val == 32'd0) ? SEED : seed_val;
      else if (last_acc) m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ POLY) : (m_lfsr >> 1);
      if (last_acc) begin
        m_ov = 1'b1; m_od = nd; m_om = nm;
      end else if (out_ready) m_ov = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data", out_data, m_od);
    chk("out_mask", {28'd0, out_mask}, {28'd0, m_om});
    chk("drop_count", {16'd0, drop_count}, m_cnt);
  endtask

  initial begin
    int          beats;
    int          cyc;
    logic [31:0] d;
    logic [31:0] held_d;
    logic [3:0]  held_m;

    vecs[0] = '{32'h807F_5090, 2'd1, 32'hFFFE_A0FF};
    vecs[1] = '{32'h1F1F_1F1F, 2'd3, 32'hF8F8_F8F8};
    vecs[2] = '{32'h3F40_0102, 2'd2, 32'hFCFF_0408};
    vecs[3] = '{32'hAB00_FF12, 2'd0, 32'hAB00_FF12};
    vecs[4] = '{32'h2021_0010, 2'd3, 32'hFFFF_0080};

    rst_n = 1'b0; ena = 1'b1; cfg_rate = 8'd0; cfg_scale = 1'b0; cfg_shift = 2'd0;
    seed_load = 1'b0; seed_val = 32'd0; stat_clr = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_data = 32'd0;
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;

    // T1: rate 0 passes everything unchanged
    for (int k = 0; k < 20; k++) begin
      d = $urandom; in_data = d; in_valid = 1'b1;
      tick();
      chk("t1_pass", out_data, d);
      chk("t1_mask", {28'd0, out_mask}, 32'h0000_000F);
    end
    chk("t1_count", {16'd0, drop_count}, 32'd0);

    // T2: saturating scale table
    cfg_scale = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cfg_shift = vecs[k].shift; in_data = vecs[k].data; in_valid = 1'b1;
      tick();
      chk("t2_scale", out_data, vecs[k].exp_data);
    end
    cfg_scale = 1'b0; cfg_shift = 2'd0;

    // T3: zero seed maps to SEED, then random stream at rate 0x80
    in_valid = 1'b0; seed_load = 1'b1; seed_val = 32'd0; stat_clr = 1'b1;
    tick();
    seed_load = 1'b0; stat_clr = 1'b0; cfg_rate = 8'h80;
    beats = 0; cyc = 0;
    while (beats < 1000 && cyc < 6000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      in_data   = $urandom;
      tick();
      if (last_acc) beats++;
      cyc++;
    end
    chk("t3_beats", beats, 32'd1000);
    chk("t3_frac", {31'd0, (drop_count >= 16'd1800 && drop_count <= 16'd2200)}, 32'd1);
    seed_load = 1'b1; seed_val = 32'h1; in_valid = 1'b1; out_ready = 1'b1; in_data = $urandom;
    tick();
    seed_load = 1'b0;
    for (int k = 0; k < 50; k++) begin
      in_data = $urandom; tick();
    end

    // T4: downstream stall then enable freeze
    out_ready = 1'b0; in_data = $urandom; tick();
    held_d = out_data; held_m = out_mask;
    for (int k = 0; k < 5; k++) begin
      in_data = $urandom; tick();
      chk("t4_stall_rdy", {31'd0, in_ready}, 32'd0);
      chk("t4_hold_data", out_data, held_d);
      chk("t4_hold_mask", {28'd0, out_mask}, {28'd0, held_m});
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = $urandom; tick();
    end
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_data = $urandom; tick();
      chk("t4_ena_drain", {31'd0, out_valid}, 32'd0);
    end
    ena = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = $urandom; tick();
    end

    // T5: saturation of the drop counter, then clear against an accept
    stat_clr = 1'b1; seed_load = 1'b1; seed_val = 32'h1; in_valid = 1'b0;
    tick();
    stat_clr = 1'b0; seed_load = 1'b0; cfg_rate = 8'hFF; in_valid = 1'b1;
    cyc = 0;
    while (m_cnt < 65535 && cyc < 20000) begin
      in_data = $urandom; tick(); cyc++;
    end
    chk("t5_sat", {16'd0, drop_count}, 32'h0000_FFFF);
    for (int k = 0; k < 5; k++) begin
      in_data = $urandom; tick();
    end
    chk("t5_no_wrap", {16'd0, drop_count}, 32'h0000_FFFF);
    stat_clr = 1'b1; tick();
    chk("t5_clr", {16'd0, drop_count}, 32'd0);
    chk("t5_clr_acc", {31'd0, last_acc}, 32'd1);
    stat_clr = 1'b0;

    // T6: reset while a beat is held
    cfg_rate = 8'h80; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
    tick();
    chk("t6_held", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0; tick();
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_data", out_data, 32'd0);
    chk("t6_count", {16'd0, drop_count}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = $urandom; tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
